psum_acc: RTL and testbench
===========================

PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 SHALL have parameter OUTPUT_NUM, default 7, number of result lanes.
REQ-002 SHALL have parameter IW, default 24, integer bits per lane word.
REQ-003 SHALL have parameter FW, default 8, fraction bits per lane word (lane width DW = IW+FW).
REQ-004 SHALL have parameter GW, default 8, accumulator guard bits (accumulator width AW = DW+GW).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, begin accumulation job (sampled only in IDLE).
REQ-008 SHALL have port cfg_ch_num, input, 16, input-channel beats per job, latched at start.
REQ-009 SHALL have port in_valid, input, 1, res_i beat valid.
REQ-010 SHALL have port in_ready, output, 1, block accepts a res_i beat.
REQ-011 SHALL have port res_i, input, OUTPUT_NUM*DW, packed signed per-channel products from the 1x1 PE; lane k at bits [k*DW+DW-1 : k*DW].
REQ-012 SHALL have port out_valid, output, 1, acc_o valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts acc_o.
REQ-014 SHALL have port acc_o, output, OUTPUT_NUM*DW, packed saturated sums, same lane packing as res_i.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse on the cycle after the output handshake.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, OUT.
REQ-018 IDLE: start=1 SHALL latch cfg_ch_num (value 0 treated as 1), clear beat counter, go to ACC next cycle; start in ACC/OUT SHALL be ignored.
REQ-019 ACC: in_ready SHALL be 1; beat accepted iff in_valid&&in_ready.
REQ-020 First accepted beat SHALL load each accumulator with sign-extended lane; later beats SHALL add sign-extended lane to accumulator, AW-bit two's complement, no wrap within GW guard.
REQ-021 On acceptance of the beat making count equal latched cfg_ch_num, SHALL go to OUT next cycle with acc_o registered and out_valid=1 that same next cycle.
REQ-022 acc_o lane SHALL be accumulator saturated to signed DW range: >2^(DW-1)-1 gives 2^(DW-1)-1; <-2^(DW-1) gives -2^(DW-1).
REQ-023 Accumulation with fixed point SHALL keep binary point at FW; no rescaling.
REQ-024 OUT: in_ready SHALL be 0; acc_o and out_valid SHALL hold stable until out_valid&&out_ready.
REQ-025 On output handshake SHALL go to IDLE and pulse done for one cycle; start in that IDLE cycle SHALL be accepted normally.
REQ-026 in_valid=0 stalls in ACC SHALL not change accumulators or counter.
REQ-027 Throughput SHALL be one beat per cycle in ACC; job latency = N beats + 1 cycle to out_valid.

Reset
REQ-028 rst=1 SHALL force IDLE, counter and accumulators 0, in_ready=0, out_valid=0, acc_o=0, busy=0, done=0, from any state including mid-job; partial job discarded.

Configuration
REQ-029 With macro PSUM_ACC_RELU_EN defined, each acc_o lane SHALL be clamped to 0 when negative after saturation.
REQ-030 Without PSUM_ACC_RELU_EN, acc_o SHALL carry signed saturated values unmodified.

Structure
REQ-031 Shared package pe_pkg SHALL hold DW/AW-derived constants, saturation limits, and FSM state typedef.
REQ-032 Per-lane saturation/ReLU SHALL be sub-module psum_sat, instantiated OUTPUT_NUM times.

Verification
REQ-033 cfg_ch_num=3, lane0 beats 256,512,-128 (1.0,2.0,-0.5), continuous valid -> out_valid 4 cycles after first beat, lane0 acc_o=640.
REQ-034 cfg_ch_num=2, lane1 beats 0x7FFFFFFF,0x00000001 -> lane1 acc_o=0x7FFFFFFF; beats 0x80000000,0xFFFFFFFF -> 0x80000000.
REQ-035 out_ready=0 for 5 cycles in OUT, in_valid toggling -> acc_o stable, in_ready=0, no beats consumed; then out_ready=1 -> done pulse next cycle.
REQ-036 rst asserted after 2 of 4 beats -> all outputs 0 next cycle; new job cfg_ch_num=1, beat 100 -> acc_o=100 (no residue).
REQ-037 cfg_ch_num=0, single beat -5 -> out_valid after one beat; acc_o=-5, or 0 with PSUM_ACC_RELU_EN.
REQ-038 start held high while busy, in_valid gapped every other cycle -> job unaffected, sum correct, counter advances only on accepted beats.

Source files
------------

// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the partial-sum accumulator:
//   - default lane geometry (integer/fraction/guard bits, derived DW and AW)
//   - cfg_ch_num width
//   - signed saturation limits as functions of the lane width
//   - FSM state type used by psum_acc
// Optional feature macro used by the block: PSUM_ACC_RELU_EN (see psum_sat).
// -----------------------------------------------------------------------------
package pe_pkg;

   localparam int DEF_IW = 24;
   localparam int DEF_FW = 8;
   localparam int DEF_GW = 8;
   localparam int DEF_DW = DEF_IW + DEF_FW;
   localparam int DEF_AW = DEF_DW + DEF_GW;

   localparam int CH_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Largest value representable in a dw-bit signed word (dw <= 63).
   function automatic longint sat_max(input int dw);
      return (longint'(1) <<< (dw - 1)) - longint'(1);
   endfunction

   // Smallest value representable in a dw-bit signed word (dw <= 63).
   function automatic longint sat_min(input int dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

endpackage

// File: rtl/psum_sat.sv
// -----------------------------------------------------------------------------
// psum_sat
// Per-lane output stage: saturates an AW-bit two's complement accumulator
// value to the signed DW-bit range. With PSUM_ACC_RELU_EN defined, negative
// saturated results are additionally clamped to zero.
// Ports:
//   acc  in   AW  accumulator value (two's complement)
//   sat  out  DW  saturated (and optionally rectified) lane word
// Purely combinational; binary point position is untouched.
// -----------------------------------------------------------------------------
module psum_sat
   import pe_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic [AW-1:0] acc,
   output logic [DW-1:0] sat
);

   // Limits sign-extended to accumulator width so the compares are exact.
   localparam logic signed [AW-1:0] MAX_V = AW'(sat_max(DW));
   localparam logic signed [AW-1:0] MIN_V = AW'(sat_min(DW));

   logic [DW-1:0] clip;

   // NOTE: every branch assigns clip, so no latch is inferred.
   always_comb begin
      if ($signed(acc) > MAX_V) begin
         clip = MAX_V[DW-1:0];
      end else if ($signed(acc) < MIN_V) begin
         clip = MIN_V[DW-1:0];
      end else begin
         clip = acc[DW-1:0];
      end
   end

`ifdef PSUM_ACC_RELU_EN
   assign sat = clip[DW-1] ? '0 : clip;
`else
   assign sat = clip;
`endif

endmodule

// File: rtl/psum_acc.sv
// -----------------------------------------------------------------------------
// psum_acc
// Accumulates cfg_ch_num beats of packed per-lane products coming from a 1x1
// PE and presents the per-lane saturated sums on a valid/ready output.
// Optional macro: PSUM_ACC_RELU_EN (negative results clamp to zero).
// Ports:
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous active-high reset
//   start       in   1            start a job (only honoured in IDLE)
//   cfg_ch_num  in   16           beats per job, latched at start (0 -> 1)
//   in_valid    in   1            res_i beat valid
//   in_ready    out  1            beat accepted when in_valid && in_ready
//   res_i       in   OUTPUT_NUM*DW  packed signed lane products
//   out_valid   out  1            acc_o valid, held until out_ready
//   out_ready   in   1            downstream accepts acc_o
//   acc_o       out  OUTPUT_NUM*DW  packed saturated lane sums
//   busy        out  1            state is not IDLE
//   done        out  1            one-cycle pulse after output handshake
// -----------------------------------------------------------------------------
module psum_acc
   import pe_pkg::*;
#(
   parameter int OUTPUT_NUM = 7,
   parameter int IW         = DEF_IW,
   parameter int FW         = DEF_FW,
   parameter int GW         = DEF_GW
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [CH_W-1:0]                cfg_ch_num,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [OUTPUT_NUM*(IW+FW)-1:0]  res_i,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUTPUT_NUM*(IW+FW)-1:0]  acc_o,
   output logic                           busy,
   output logic                           done
);

   localparam int DW = IW + FW;
   localparam int AW = DW + GW;

   state_t state, state_nxt;

   logic [CH_W-1:0] ch_num;
   logic [CH_W-1:0] beat_cnt;
   logic            accept;
   logic            first_beat;
   logic            last_beat;

   logic [OUTPUT_NUM-1:0][AW-1:0] acc_q;
   logic [OUTPUT_NUM-1:0][AW-1:0] acc_nxt;
   logic [OUTPUT_NUM*DW-1:0]      sat_w;

   assign accept     = in_valid && in_ready;
   assign first_beat = (beat_cnt == '0);
   // Widened by one bit so a full 16-bit count cannot wrap in the compare.
   assign last_beat  = (({1'b0, beat_cnt} + 17'd1) == {1'b0, ch_num});

   // Per-lane datapath: first beat loads, later beats add; the guard bits
   // absorb growth so nothing wraps before the saturation stage.
   for (genvar k = 0; k < OUTPUT_NUM; k++) begin : g_lane
      logic [DW-1:0] lane;
      logic [AW-1:0] lane_ext;

      assign lane     = res_i[k*DW +: DW];
      assign lane_ext = {{GW{lane[DW-1]}}, lane};
      assign acc_nxt[k] = first_beat ? lane_ext : acc_q[k] + lane_ext;

      // The saturator sees the post-add value so acc_o can be registered on
      // the same edge that accepts the final beat.
      psum_sat #(
         .DW (DW),
         .AW (AW)
      ) u_sat (
         .acc (acc_nxt[k]),
         .sat (sat_w[k*DW +: DW])
      );
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ST_ACC;
         end
         ST_ACC: begin
            in_ready = 1'b1;
            if (accept && last_beat) state_nxt = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the
   // accumulators are cleared on reset as well so an aborted job leaves no
   // residue for the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ch_num   <= '0;
         beat_cnt <= '0;
         acc_q    <= '0;
         acc_o    <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == ST_OUT) && out_ready;

         if ((state == ST_IDLE) && start) begin
            ch_num   <= (cfg_ch_num == '0) ? CH_W'(1) : cfg_ch_num;
            beat_cnt <= '0;
         end

         if (accept) begin
            acc_q    <= acc_nxt;
            beat_cnt <= beat_cnt + CH_W'(1);
            if (last_beat) acc_o <= sat_w;
         end
      end
   end

endmodule

// File: tb/tb_psum_acc.sv
// -----------------------------------------------------------------------------
// tb_psum_acc
// Directed self-checking bench for psum_acc with default parameters
// (7 lanes, 32-bit lanes). Expected sums are hand-computed constants.
// Honour PSUM_ACC_RELU_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_psum_acc;

   localparam int ON = 7;
   localparam int DW = 32;
   localparam int VW = ON * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   cfg_ch_num;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] res_i;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] acc_o;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [VW-1:0] beats [8];
   logic [VW-1:0] exp_v;
   int            cyc;

   always #5 clk = ~clk;

   psum_acc #(
      .OUTPUT_NUM (ON),
      .IW         (24),
      .FW         (8),
      .GW         (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_ch_num (cfg_ch_num),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .res_i      (res_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .acc_o      (acc_o),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] rl(input logic [DW-1:0] v);
`ifdef PSUM_ACC_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [VW-1:0] put(input logic [VW-1:0] vec, input int k,
                                         input logic [DW-1:0] v);
      logic [VW-1:0] r;
      r = vec;
      r[k*DW +: DW] = v;
      return r;
   endfunction

   task automatic clear_beats();
      for (int i = 0; i < 8; i++) beats[i] = '0;
   endtask

   task automatic start_job(input logic [15:0] ch);
      @(negedge clk);
      cfg_ch_num = ch;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      cfg_ch_num = 16'hBEEF;
      check("busy_in_acc", busy, 1);
      check("in_ready_in_acc", in_ready, 1);
   endtask

   task automatic feed(input int n, input bit gapped, input bit hold);
      for (int i = 0; i < n; i++) begin
         if (gapped) begin
            in_valid = 1'b0;
            res_i    = {ON{32'h0BADF00D}};
            start    = hold;
            @(negedge clk);
         end
         res_i    = beats[i];
         in_valid = 1'b1;
         start    = hold;
         @(negedge clk);
         if (i < n - 1) check("no_early_out", out_valid, 0);
      end
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic finish_job(input string tag);
      check({tag, "_out_valid"}, out_valid, 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_done"}, done, 1);
      check({tag, "_idle_ov"}, out_valid, 0);
      check({tag, "_idle_busy"}, busy, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      cfg_ch_num = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      res_i      = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_acc_o", acc_o, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;

      // Fixed-point sum 1.0 + 2.0 - 0.5 on lane0, -1.0 x3 on lane2; latency.
      clear_beats();
      beats[0] = put(put('0, 0, 32'h00000100), 2, 32'hFFFFFF00);
      beats[1] = put(put('0, 0, 32'h00000200), 2, 32'hFFFFFF00);
      beats[2] = put(put('0, 0, 32'hFFFFFF80), 2, 32'hFFFFFF00);
      start_job(16'd3);
      cyc      = 1;
      res_i    = beats[0];
      in_valid = 1'b1;
      for (int g = 0; g < 20; g++) begin
         @(negedge clk);
         cyc++;
         if (out_valid) break;
         if (cyc - 1 < 3) res_i = beats[cyc-1];
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check("latency_cycle", 32'(cyc), 32'd4);
      exp_v = put(put('0, 0, 32'h00000280), 2, rl(32'hFFFFFD00));
      check("fx_sum", acc_o, exp_v);
      finish_job("fx");

      // Positive saturation on lane1, plain sum on lane6.
      clear_beats();
      beats[0] = put(put('0, 1, 32'h7FFFFFFF), 6, 32'h00001000);
      beats[1] = put(put('0, 1, 32'h00000001), 6, 32'h00000234);
      start_job(16'd2);
      feed(2, 1'b0, 1'b0);
      exp_v = put(put('0, 1, 32'h7FFFFFFF), 6, 32'h00001234);
      check("sat_pos", acc_o, exp_v);
      finish_job("satp");

      // Negative saturation on lane1, positive saturation on lane6.
      clear_beats();
      beats[0] = put(put('0, 1, 32'h80000000), 6, 32'h7FFFFFFF);
      beats[1] = put(put('0, 1, 32'hFFFFFFFF), 6, 32'h7FFFFFFF);
      start_job(16'd2);
      feed(2, 1'b0, 1'b0);
      exp_v = put(put('0, 1, rl(32'h80000000)), 6, 32'h7FFFFFFF);
      check("sat_neg", acc_o, exp_v);
      finish_job("satn");

      // Output back-pressure: hold stable, consume nothing.
      clear_beats();
      beats[0] = put('0, 3, 32'd10);
      beats[1] = put('0, 3, 32'd20);
      start_job(16'd2);
      feed(2, 1'b0, 1'b0);
      exp_v = put('0, 3, 32'd30);
      check("bp_sum", acc_o, exp_v);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         res_i    = {ON{32'h12345678}};
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_acc_stable", acc_o, exp_v);
      end
      in_valid = 1'b0;
      finish_job("bp");
      clear_beats();
      beats[0] = put('0, 3, 32'd7);
      start_job(16'd1);
      feed(1, 1'b0, 1'b0);
      check("bp_next_job", acc_o, put('0, 3, 32'd7));
      finish_job("bpn");

      // Reset mid-job, then a fresh single-beat job.
      clear_beats();
      beats[0] = put('0, 0, 32'd1000);
      beats[1] = put('0, 0, 32'd2000);
      start_job(16'd4);
      feed(2, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_acc_o", acc_o, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      rst = 1'b0;
      clear_beats();
      beats[0] = put('0, 0, 32'd100);
      start_job(16'd1);
      feed(1, 1'b0, 1'b0);
      check("post_rst_sum", acc_o, put('0, 0, 32'd100));
      finish_job("prst");

      // cfg_ch_num = 0 behaves as a single-beat job.
      clear_beats();
      beats[0] = put('0, 5, 32'hFFFFFFFB);
      start_job(16'd0);
      feed(1, 1'b0, 1'b0);
      check("ch0_sum", acc_o, put('0, 5, rl(32'hFFFFFFFB)));
      finish_job("ch0");

      // start held while busy, gapped input.
      clear_beats();
      beats[0] = put(put('0, 4, 32'd5), 0, 32'hFFFFFFFF);
      beats[1] = put(put('0, 4, 32'd6), 0, 32'hFFFFFFFF);
      beats[2] = put(put('0, 4, 32'd7), 0, 32'hFFFFFFFF);
      start_job(16'd3);
      feed(3, 1'b1, 1'b1);
      exp_v = put(put('0, 4, 32'd18), 0, rl(32'hFFFFFFFD));
      check("gap_sum", acc_o, exp_v);
      finish_job("gap");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
